// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants, counter width and colours
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_ACT_START = 144;
  localparam int DEF_H_ACT_END   = 784;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_ACT_START = 35;
  localparam int DEF_V_ACT_END   = 515;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] GREY  = 12'h888;
  localparam logic [11:0] GREEN = 12'h0f0;

  // Compare in int so limits equal to 1024 stay representable.
  function automatic logic cnt_below(input logic [CNT_W-1:0] c, input int lim);
    return int'(c) < lim;
  endfunction

  function automatic logic cnt_in_span(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return !(int'(c) < lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/pixel_en_div.sv
// rtl/pixel_en_div.sv - modulo-CLK_DIV divider producing a registered one-clk pixel strobe
module pixel_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pixel_en_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pixel_en_q, pixel_en_d;

  // The strobe is decoded from the next divider value so it is high while div == CLK_DIV-1.
  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pixel_en_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q      <= '0;
      pixel_en_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pixel_en_q <= pixel_en_d;
    end
  end

  assign pixel_en_o = pixel_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with registered sync, bright and tick decodes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_END   = DEF_H_ACT_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT_END   = DEF_V_ACT_END
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pixel_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             line_tick,
  output logic             frame_tick
);

  if (CLK_DIV < 2 || H_TOTAL < 2 || V_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: unsupported timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             pixel_en_w;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             bright_q, bright_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;

  pixel_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_en_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .pixel_en_o (pixel_en_w)
  );

  // Counters advance on the edge that ends a pixel_en cycle; decodes use the next values
  // so every output lands on the same edge as the counters.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (pixel_en_w) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hsync_d  = !cnt_below(h_d, H_SYNC);
    vsync_d  = !cnt_below(v_d, V_SYNC);
    bright_d = cnt_in_span(h_d, H_ACT_START, H_ACT_END) &&
               cnt_in_span(v_d, V_ACT_START, V_ACT_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign pixel_en   = pixel_en_w;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign bright     = bright_q;
  assign line_tick  = line_q;
  assign frame_tick = frame_q;

endmodule
